// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the sprite draw path: default origin/colour widths,
// the scheduler state encoding, the square size used by the shape FSM, and a
// small index-wrap helper used by the round-robin pointer.
// No ports (package).
// -----------------------------------------------------------------------------
package draw_pkg;

  localparam int X_W_DEF     = 8;
  localparam int Y_W_DEF     = 7;
  localparam int COLOR_W_DEF = 3;

  // Edge length of the square the shape FSM draws, in pixels.
  localparam int SHAPE_SIZE  = 60;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Next index after idx, wrapping to 0 at n.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// -----------------------------------------------------------------------------
// draw_scheduler_if
// Bundles the requester side (req / origin / colour / hold / ack) and the
// drawer side (start pulse, done level, latched origin and colour) of the
// draw scheduler.
//   modport slave  : the scheduler (consumes requests, drives the drawer)
//   modport master : game logic + drawer model (issues requests, reports done)
// -----------------------------------------------------------------------------
interface draw_scheduler_if
  import draw_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) ();

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*X_W-1:0]     req_x;
  logic [NUM_REQ*Y_W-1:0]     req_y;
  logic [NUM_REQ*COLOR_W-1:0] req_colour;
  logic                       hold;
  logic [NUM_REQ-1:0]         ack;

  logic                       shape_start;
  logic                       shape_done;
  logic [X_W-1:0]             shape_x;
  logic [Y_W-1:0]             shape_y;
  logic [COLOR_W-1:0]         shape_colour;

  modport slave (
    input  req, req_x, req_y, req_colour, hold, shape_done,
    output ack, shape_start, shape_x, shape_y, shape_colour
  );

  modport master (
    output req, req_x, req_y, req_colour, hold, shape_done,
    input  ack, shape_start, shape_x, shape_y, shape_colour
  );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: scans req starting at ptr, wrapping modulo
// N, and reports the first set bit.
//   req   in  N        request vector
//   ptr   in  log2(N)  index where the search starts
//   gnt   out N        one-hot winner (0 when nothing requested)
//   idx   out log2(N)  winner index
//   valid out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  int            pos;
  logic [IW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      j = IW'(pos);
      if (!valid && req[j]) begin
        valid  = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// -----------------------------------------------------------------------------
// draw_scheduler
// Shares one square-drawing shape FSM among NUM_REQ sprite requesters.
// A round-robin winner's origin/colour is latched onto the drawer inputs,
// the drawer is started, its done level is tracked through the draw, and the
// requester is acknowledged with a one-cycle pulse when the shape is finished.
// A drawer that never leaves idle after a start raises a sticky err and the
// requester is still acknowledged.
//   clock     in   system clock (rising edge)
//   resetn    in   asynchronous active-low reset
//   bus       slave modport: req/req_x/req_y/req_colour/hold in, ack out;
//             shape_done in, shape_start/shape_x/shape_y/shape_colour out
//   grant_id  out  index of the current/last granted requester
//   busy      out  high whenever not idle
//   err       out  sticky start-timeout flag
// -----------------------------------------------------------------------------
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int X_W           = X_W_DEF,
  parameter int Y_W           = Y_W_DEF,
  parameter int COLOR_W       = COLOR_W_DEF,
  parameter int START_TIMEOUT = 8
) (
  input  logic                       clock,
  input  logic                       resetn,
  draw_scheduler_if.slave            bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] grant_oh;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  logic               grant_ok;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // No grant in the ack cycle: a requester that has not yet dropped req on
  // its ack is only seen as a fresh request one cycle later.
  assign grant_ok = !bus.hold && bus.shape_done && arb_valid && (bus.ack == '0);

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state            <= IDLE;
      ptr              <= '0;
      grant_id         <= '0;
      grant_oh         <= '0;
      cnt              <= '0;
      err              <= 1'b0;
      bus.ack          <= '0;
      bus.shape_start  <= 1'b0;
      bus.shape_x      <= '0;
      bus.shape_y      <= '0;
      bus.shape_colour <= '0;
    end else begin
      bus.shape_start <= 1'b0;
      bus.ack         <= '0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            bus.shape_x      <= bus.req_x[arb_idx*X_W +: X_W];
            bus.shape_y      <= bus.req_y[arb_idx*Y_W +: Y_W];
            bus.shape_colour <= bus.req_colour[arb_idx*COLOR_W +: COLOR_W];
            grant_id         <= arb_idx;
            grant_oh         <= arb_gnt;
            bus.shape_start  <= 1'b1;
            state            <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!bus.shape_done) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
            // Drawer never started: flag it but release the requester.
            err     <= 1'b1;
            bus.ack <= grant_oh;
            ptr     <= IW'(next_idx(int'(grant_id), NUM_REQ));
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (bus.shape_done) begin
            bus.ack <= grant_oh;
            ptr     <= IW'(next_idx(int'(grant_id), NUM_REQ));
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int T  = 8;

  logic          clock;
  logic          resetn;
  logic [1:0]    grant_id;
  logic          busy;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ptr = 0;

  // drawer model controls
  int draw_len = 10;
  bit no_drop  = 0;
  bit armed    = 0;
  int remaining = 0;

  logic [XW-1:0] xs [N];
  logic [YW-1:0] ys [N];
  logic [CW-1:0] cs [N];

  draw_scheduler_if #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) bus ();

  draw_scheduler #(
    .NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .START_TIMEOUT(T)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drawer: sees start, leaves idle one cycle later, stays busy draw_len
  // cycles, then returns to idle. With no_drop set it never leaves idle.
  initial begin
    bus.shape_done = 1'b1;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        bus.shape_done = 1'b1;
        armed = 0;
        remaining = 0;
      end else begin
        if (armed) begin
          armed = 0;
          if (!no_drop) begin
            bus.shape_done = 1'b0;
            remaining = draw_len;
          end
        end else if (remaining > 0) begin
          remaining--;
          if (remaining == 0) bus.shape_done = 1'b1;
        end
        if (bus.shape_start === 1'b1) armed = 1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    bus.req = '0;
    bus.hold = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    exp_ptr = 0;
  endtask

  task automatic set_coords(input int i, input logic [XW-1:0] x,
                            input logic [YW-1:0] y, input logic [CW-1:0] c);
    xs[i] = x; ys[i] = y; cs[i] = c;
    bus.req_x[i*XW +: XW]      = x;
    bus.req_y[i*YW +: YW]      = y;
    bus.req_colour[i*CW +: CW] = c;
  endtask

  task automatic wait_start(input int limit, output int ticks, output bit ok);
    ok = 0;
    ticks = limit;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (bus.shape_start === 1'b1) begin
        ticks = k;
        ok = 1;
        return;
      end
    end
  endtask

  task automatic wait_ack(input int limit, output int ticks, output bit ok);
    ok = 0;
    ticks = limit;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (bus.ack !== '0) begin
        ticks = k;
        ok = 1;
        return;
      end
    end
  endtask

  // Reference round robin: first requesting index at or after p, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (bus.ack !== 4'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0000", bus.ack); end
    n_cmp++; if (bus.shape_start !== 1'b0) begin n_bad++; $display("FAIL reset_start got=%b exp=0", bus.shape_start); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    n_cmp++; if ({bus.shape_x, bus.shape_y, bus.shape_colour} !== '0) begin n_bad++;
      $display("FAIL reset_shape got=%0d/%0d/%0d exp=0/0/0", bus.shape_x, bus.shape_y, bus.shape_colour); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int t; bit ok;
    set_coords(1, 8'd20, 7'd30, 3'b101);
    draw_len = 100;
    bus.req = 4'b0010;
    wait_start(5, t, ok);
    n_cmp++; if (!ok || t != 1) begin n_bad++; $display("FAIL single_start_lat got=%0d exp=1", t); end
    n_cmp++; if (bus.shape_x !== 8'd20) begin n_bad++; $display("FAIL single_x got=%0d exp=20", bus.shape_x); end
    n_cmp++; if (bus.shape_y !== 7'd30) begin n_bad++; $display("FAIL single_y got=%0d exp=30", bus.shape_y); end
    n_cmp++; if (bus.shape_colour !== 3'd5) begin n_bad++; $display("FAIL single_colour got=%0d exp=5", bus.shape_colour); end
    n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL single_grant got=%0d exp=1", grant_id); end
    tick();
    n_cmp++; if (bus.shape_start !== 1'b0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL single_start_pulse got start=%b busy=%b exp start=0 busy=1", bus.shape_start, busy); end
    wait_ack(300, t, ok);
    n_cmp++; if (!ok || t != draw_len + 1) begin n_bad++; $display("FAIL single_ack_lat got=%0d exp=%0d", t, draw_len + 1); end
    n_cmp++; if (bus.ack !== 4'b0010) begin n_bad++; $display("FAIL single_ack got=%b exp=0010", bus.ack); end
    bus.req = 4'b0000;
    tick();
    n_cmp++; if (bus.ack !== 4'b0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL single_after got ack=%b busy=%b exp ack=0000 busy=0", bus.ack, busy); end
    exp_ptr = 2;
  endtask

  task automatic test_round_robin();
    int t; bit ok; int w; int prev;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++)
      set_coords(i, XW'($urandom), YW'($urandom), CW'($urandom));
    bus.req = 4'b1111;
    prev = -1;
    for (int g = 0; g < 5; g++) begin
      draw_len = $urandom_range(2, 20);
      w = rr_pick(bus.req, exp_ptr);
      wait_start(10, t, ok);
      n_cmp++; if (!ok || int'(grant_id) != order[g] || w != order[g]) begin n_bad++;
        $display("FAIL rr_grant[%0d] got=%0d exp=%0d", g, grant_id, order[g]); end
      n_cmp++; if (int'(grant_id) == prev) begin n_bad++; $display("FAIL rr_repeat[%0d] got=%0d exp!=%0d", g, grant_id, prev); end
      n_cmp++; if (bus.shape_x !== xs[w]) begin n_bad++; $display("FAIL rr_x[%0d] got=%0d exp=%0d", g, bus.shape_x, xs[w]); end
      prev = int'(grant_id);
      wait_ack(100, t, ok);
      n_cmp++; if (!ok || bus.ack !== 4'(1 << w)) begin n_bad++; $display("FAIL rr_ack[%0d] got=%b exp=%b", g, bus.ack, 4'(1 << w)); end
      bus.req[w] = 1'b0;
      exp_ptr = (w + 1) % N;
      tick();
      n_cmp++; if (bus.ack !== 4'b0) begin n_bad++; $display("FAIL rr_ack_pulse[%0d] got=%b exp=0000", g, bus.ack); end
      bus.req[w] = 1'b1;
    end
    bus.req = 4'b0000;
    repeat (30) tick();
  endtask

  task automatic test_back_to_back();
    int t; bit ok;
    do_reset();
    set_coords(0, 8'd5, 7'd6, 3'd7);
    draw_len = $urandom_range(3, 15);
    bus.req = 4'b0001;
    wait_start(5, t, ok);
    wait_ack(100, t, ok);
    n_cmp++; if (!ok || bus.ack !== 4'b0001) begin n_bad++; $display("FAIL b2b_ack got=%b exp=0001", bus.ack); end
    // req left high through the ack cycle: seen as a new request one cycle on
    wait_start(10, t, ok);
    n_cmp++; if (!ok || t != 2) begin n_bad++; $display("FAIL b2b_gap got=%0d exp=2", t); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL b2b_grant got=%0d exp=0", grant_id); end
    bus.req = 4'b0000;
    wait_ack(100, t, ok);
    n_cmp++; if (!ok || bus.ack !== 4'b0001) begin n_bad++; $display("FAIL b2b_ack2 got=%b exp=0001", bus.ack); end
    tick();
  endtask

  task automatic test_random();
    int t; bit ok; int w;
    logic [N-1:0] pend, nw;
    do_reset();
    pend = '0;
    for (int r = 0; r < 30; r++) begin
      nw = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        if (nw[i] && !pend[i]) begin
          set_coords(i, XW'($urandom), YW'($urandom), CW'($urandom));
          pend[i] = 1'b1;
        end
      if (pend == '0) begin
        w = $urandom_range(0, N - 1);
        set_coords(w, XW'($urandom), YW'($urandom), CW'($urandom));
        pend[w] = 1'b1;
      end
      bus.req = pend;
      draw_len = $urandom_range(1, 30);
      w = rr_pick(pend, exp_ptr);
      wait_start(5, t, ok);
      n_cmp++; if (!ok || t != 1) begin n_bad++; $display("FAIL rnd_start_lat[%0d] got=%0d exp=1", r, t); end
      n_cmp++; if (grant_id !== 2'(w)) begin n_bad++; $display("FAIL rnd_grant[%0d] got=%0d exp=%0d req=%b", r, grant_id, w, pend); end
      n_cmp++; if ({bus.shape_x, bus.shape_y, bus.shape_colour} !== {xs[w], ys[w], cs[w]}) begin n_bad++;
        $display("FAIL rnd_shape[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", r, bus.shape_x, bus.shape_y, bus.shape_colour, xs[w], ys[w], cs[w]); end
      wait_ack(100, t, ok);
      n_cmp++; if (!ok || t != draw_len + 2) begin n_bad++; $display("FAIL rnd_ack_lat[%0d] got=%0d exp=%0d", r, t, draw_len + 2); end
      n_cmp++; if (bus.ack !== N'(1 << w)) begin n_bad++; $display("FAIL rnd_ack[%0d] got=%b exp=%b", r, bus.ack, N'(1 << w)); end
      pend[w] = 1'b0;
      bus.req = pend;
      exp_ptr = (w + 1) % N;
      tick();
      n_cmp++; if (bus.ack !== '0) begin n_bad++; $display("FAIL rnd_ack_pulse[%0d] got=%b exp=0000", r, bus.ack); end
    end
    bus.req = '0;
    repeat (40) tick();
  endtask

  task automatic test_hold();
    int t; bit ok; int starts;
    do_reset();
    set_coords(0, 8'd11, 7'd12, 3'd3);
    bus.hold = 1'b1;
    bus.req = 4'b0001;
    starts = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus.shape_start === 1'b1 || busy === 1'b1) starts++;
    end
    n_cmp++; if (starts != 0) begin n_bad++; $display("FAIL hold_block got=%0d exp=0", starts); end
    draw_len = 40;
    bus.hold = 1'b0;
    wait_start(5, t, ok);
    n_cmp++; if (!ok || t != 1) begin n_bad++; $display("FAIL hold_release got=%0d exp=1", t); end
    repeat (5) tick();
    bus.hold = 1'b1;
    wait_ack(100, t, ok);
    n_cmp++; if (!ok || bus.ack !== 4'b0001) begin n_bad++; $display("FAIL hold_middraw_ack got=%b exp=0001", bus.ack); end
    bus.req = 4'b0000;
    tick();
    bus.hold = 1'b0;
    tick();
  endtask

  task automatic test_mid_draw();
    int t; bit ok;
    set_coords(3, 8'd77, 7'd44, 3'd2);
    draw_len = 30;
    bus.req = 4'b1000;
    wait_start(5, t, ok);
    repeat (3) tick();
    bus.req_x[3*XW +: XW] = 8'd200;
    bus.req = 4'b0000;
    tick();
    n_cmp++; if (bus.shape_x !== 8'd77) begin n_bad++; $display("FAIL mid_x_during got=%0d exp=77", bus.shape_x); end
    wait_ack(100, t, ok);
    n_cmp++; if (!ok || bus.ack !== 4'b1000) begin n_bad++; $display("FAIL mid_ack got=%b exp=1000", bus.ack); end
    repeat (3) tick();
    n_cmp++; if (bus.shape_x !== 8'd77 || busy !== 1'b0) begin n_bad++;
      $display("FAIL mid_after got x=%0d busy=%b exp x=77 busy=0", bus.shape_x, busy); end
  endtask

  task automatic test_timeout();
    int t; bit ok;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_err_before got=%b exp=0", err); end
    set_coords(2, 8'd9, 7'd9, 3'd1);
    no_drop = 1;
    bus.req = 4'b0100;
    wait_start(5, t, ok);
    wait_ack(50, t, ok);
    n_cmp++; if (!ok || t != T + 1) begin n_bad++; $display("FAIL to_lat got=%0d exp=%0d", t, T + 1); end
    n_cmp++; if (bus.ack !== 4'b0100) begin n_bad++; $display("FAIL to_ack got=%b exp=0100", bus.ack); end
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL to_err got err=%b busy=%b exp err=1 busy=0", err, busy); end
    bus.req = 4'b0000;
    no_drop = 0;
    repeat (20) tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid_draw();
    int t; bit ok; int starts;
    set_coords(1, 8'd50, 7'd60, 3'd6);
    draw_len = 50;
    bus.req = 4'b0010;
    wait_start(5, t, ok);
    repeat (5) tick();
    resetn = 1'b0;
    bus.req = 4'b0000;
    #1;
    n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rmid_ctrl got busy=%b err=%b exp 0/0", busy, err); end
    n_cmp++; if (grant_id !== 2'd0 || bus.ack !== 4'b0 || bus.shape_start !== 1'b0) begin n_bad++;
      $display("FAIL rmid_out got grant=%0d ack=%b start=%b exp 0/0000/0", grant_id, bus.ack, bus.shape_start); end
    n_cmp++; if ({bus.shape_x, bus.shape_y, bus.shape_colour} !== '0) begin n_bad++;
      $display("FAIL rmid_shape got=%0d/%0d/%0d exp=0/0/0", bus.shape_x, bus.shape_y, bus.shape_colour); end
    repeat (2) tick();
    resetn = 1'b1;
    starts = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.shape_start === 1'b1 || busy === 1'b1 || bus.ack !== 4'b0) starts++;
    end
    n_cmp++; if (starts != 0) begin n_bad++; $display("FAIL rmid_idle got=%0d exp=0", starts); end
  endtask

  initial begin
    resetn = 1'b0;
    bus.req = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_colour = '0;
    bus.hold = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_random();
    test_hold();
    test_mid_draw();
    test_timeout();
    test_reset_mid_draw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Round-robin scheduler that shares the single square-drawing shape FSM among several sprite requesters, such as note lanes, the cursor and the hit marker. Each requester presents an origin and a colour. The scheduler grants one requester at a time, latches its parameters onto the drawer's address and colour inputs, and starts the drawer. It then tracks the drawer's done level through the full draw and acknowledges the requester when the shape is finished. It sits between the game logic and the shape FSM / VGA write path.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- X_W, 8, origin x width
- Y_W, 7, origin y width
- COLOR_W, 3, colour width
- START_TIMEOUT, 8, cycles allowed for drawer to drop done after start
- clock  in  1  system clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester draw request, level; hold until ack
- req_x  in  NUM_REQ*X_W  packed origin x, slice i for requester i; stable while req[i]
- req_y  in  NUM_REQ*Y_W  packed origin y
- req_colour  in  NUM_REQ*COLOR_W  packed colour
- hold  in  1  when high, no new grant issued (screen clear in progress); an in-flight draw completes
- ack  out  NUM_REQ  one-cycle pulse on bit i when requester i's shape is finished
- shape_start  out  1  one-cycle pulse to drawer's startingAddressLoaded
- shape_done  in  1  drawer's shapeDone level: high when drawer idle
- shape_x  out  X_W  registered origin x for drawer
- shape_y  out  Y_W  registered origin y
- shape_colour  out  COLOR_W  registered colour
- grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
- busy  out  1  high in every state except IDLE
- err  out  1  sticky timeout flag; cleared only by reset

## Operation
- States: IDLE, START, WAIT_LOW, WAIT_DONE.
- IDLE:
  - If hold==0, shape_done==1 and |req, pick a winner by round robin.
  - Search starts at ptr and wraps modulo NUM_REQ; the first set bit wins.
  - At the edge, register the winner's x/y/colour into shape_x/y/colour, set grant_id, and go to START.
  - Otherwise stay in IDLE.
- START: shape_start=1 for exactly one cycle, then go to WAIT_LOW with the timeout counter cleared.
- WAIT_LOW:
  - If shape_done==0, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches START_TIMEOUT-1 with shape_done still 1:
    - set err,
    - pulse ack[grant_id] so the requester is not stranded,
    - advance ptr,
    - go to IDLE.
- WAIT_DONE:
  - When shape_done==1, pulse ack[grant_id] for one cycle.
  - Set ptr = grant_id+1, wrapping at NUM_REQ to 0.
  - Go to IDLE.
- shape_x/y/colour hold their value from grant until the next grant; they never change mid-draw.
- If req[grant_id] drops mid-draw, the draw still completes and ack is still pulsed (requester ignores it).
- A requester still high in the cycle after its ack is treated as a new request. Requesters must drop req on ack.
- If hold rises mid-draw, the current draw finishes. hold only gates the IDLE grant decision.
- If req is all-zero or hold==1, the block stays in IDLE and all pulses are 0.

## Timing
- Reset values (asynchronous, resetn low):
  - state=IDLE, ptr=0, grant_id=0, shape_x/y/colour=0
  - shape_start=0, ack=0, busy=0, err=0, timeout counter=0
- Latency, req sampled high in IDLE at edge N:
  - shape_start is high during cycle N+1.
  - The drawer leaves idle at N+2 and its done level falls.
  - WAIT_LOW sees shape_done low and exits to WAIT_DONE at the following edge.
- ack is high in the cycle after shape_done is sampled high in WAIT_DONE.
- Back-to-back grants: IDLE follows ack. The next shape_start comes no earlier than 2 cycles after an ack pulse.
- Throughput is bounded by the drawer: one shape per drawer draw time plus 4 cycles of overhead.
- Reset mid-draw returns the block to IDLE immediately, with no ack for the aborted draw. The drawer is reset by the same system reset.

## Structure
- Shared package draw_pkg holds:
  - X_W, Y_W and COLOR_W defaults,
  - the state enum (IDLE, START, WAIT_LOW, WAIT_DONE),
  - the shape size constant (60) used by the shape FSM.
- Sub-module rr_arbiter (parameter N) is natural:
  - combinational: req vector + ptr in, one-hot grant + index + valid out;
  - ptr stays in draw_scheduler.
- The top is the state machine, parameter registers, timeout counter and ack decode.

## Test plan
- Single request: req=4'b0010, x=20, y=30, colour=3'b101.
  - Expect shape_start one cycle later; shape_x=20, shape_y=30, shape_colour=5.
  - Model drawer done low for 100 cycles, then high → ack=4'b0010 single pulse, busy low the next cycle.
- Round robin: all four req high continuously, re-raised after each ack. Grant order must be 0,1,2,3,0; no requester is granted twice in a row.
- Timeout: drawer model keeps shape_done=1 after shape_start → after START_TIMEOUT cycles err=1, ack pulses for the granted requester, state returns to IDLE; err stays 1 afterwards.
- hold: req=4'b0001 with hold=1 for 50 cycles → no shape_start. Drop hold → shape_start next cycle. Raise hold mid-draw → ack still arrives.
- Mid-draw changes: change req_x of the granted requester and drop its req during WAIT_DONE → shape_x unchanged, ack still pulses.
- Reset mid-draw: assert resetn=0 during WAIT_DONE → all outputs return to reset values asynchronously; after release the block idles until a new req.
